// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM encoding,
// Avalon word addresses and the default expected ID/timestamp.
package niosii_system_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_RD_TS  = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1459998803;

  // READ_LATENCY is limited to 0..3, so two bits cover the latency countdown.
  localparam int LAT_W = 2;

  // The word address is a pure function of which read the FSM is performing.
  function automatic logic addr_of(state_e s);
    return (s == ST_RD_TS || s == ST_LAT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  endfunction

endpackage

// File: rtl/niosii_system_sysid_checker_timeout_cnt.sv
// Per-read watchdog: loadable down-counter that flags the TIMEOUT_CYCLES-th
// enabled cycle since the last clear.
module niosii_system_sysid_checker_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Clear reloads the full budget; the count then reaches 1 on the last allowed cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CNT_W'(TIMEOUT_CYCLES);
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = enable && (cnt == CNT_W'(1));

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words
// and reports whether they match the expected build.
module niosii_system_sysid_checker
  import niosii_system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout_err,
  output logic [2:0]  fsm_state
);

  // Handshake: a read is accepted in the cycle av_read=1 and av_waitrequest=0;
  // while stalled, av_read and av_address hold; data arrives READ_LATENCY cycles later.

  localparam logic [LAT_W-1:0] LAT_INIT =
    (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;

  state_e           state, state_next;
  logic             auto_pending;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;
  logic             go, cap_id, cap_ts, abort;
  logic             tmo_clear, tmo_enable, tmo_expire;

  assign accept     = av_read && !av_waitrequest;
  assign av_address = addr_of(state);
  assign fsm_state  = state;

  niosii_system_sysid_checker_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expire  (tmo_expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A read that completes in its last allowed cycle wins over the timeout;
  // an accept with data still in flight does not.
  always_comb begin
    state_next = state;
    tmo_clear  = 1'b0;
    tmo_enable = 1'b0;
    go         = 1'b0;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start || auto_pending) begin
          go         = 1'b1;
          tmo_clear  = 1'b1;
          state_next = ST_RD_ID;
        end
      end
      ST_RD_ID: begin
        tmo_enable = 1'b1;
        if (tmo_expire && !(accept && READ_LATENCY == 0)) begin
          abort      = 1'b1;
          state_next = ST_FINISH;
        end else if (accept) begin
          if (READ_LATENCY == 0) begin
            cap_id     = 1'b1;
            tmo_clear  = 1'b1;
            state_next = ST_RD_TS;
          end else begin
            state_next = ST_LAT_ID;
          end
        end
      end
      ST_LAT_ID: begin
        tmo_enable = 1'b1;
        if (lat_cnt == '0) begin
          cap_id     = 1'b1;
          tmo_clear  = 1'b1;
          state_next = ST_RD_TS;
        end else if (tmo_expire) begin
          abort      = 1'b1;
          state_next = ST_FINISH;
        end
      end
      ST_RD_TS: begin
        tmo_enable = 1'b1;
        if (tmo_expire && !(accept && READ_LATENCY == 0)) begin
          abort      = 1'b1;
          state_next = ST_FINISH;
        end else if (accept) begin
          if (READ_LATENCY == 0) begin
            cap_ts     = 1'b1;
            state_next = ST_FINISH;
          end else begin
            state_next = ST_LAT_TS;
          end
        end
      end
      ST_LAT_TS: begin
        tmo_enable = 1'b1;
        if (lat_cnt == '0) begin
          cap_ts     = 1'b1;
          state_next = ST_FINISH;
        end else if (tmo_expire) begin
          abort      = 1'b1;
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pending <= AUTO_START;
      av_read      <= 1'b0;
      lat_cnt      <= '0;
      id_value     <= '0;
      ts_value     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      match        <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        auto_pending <= 1'b0;
        busy         <= 1'b1;
        match        <= 1'b0;
        timeout_err  <= 1'b0;
        av_read      <= 1'b1;
      end
      // RD_TS is entered with av_read low, which yields the idle gap between reads.
      if (state == ST_RD_TS && !av_read) begin
        av_read <= 1'b1;
      end
      if (accept || abort) begin
        av_read <= 1'b0;
      end
      if (abort) begin
        timeout_err <= 1'b1;
      end
      if (accept) begin
        lat_cnt <= LAT_INIT;
      end else if ((state == ST_LAT_ID || state == ST_LAT_TS) && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (cap_id) begin
        id_value <= av_readdata;
      end
      if (cap_ts) begin
        ts_value <= av_readdata;
      end
      if (state == ST_FINISH) begin
        match <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP) && !timeout_err;
        done  <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Randomized bench for the sysid checker: two instances (READ_LATENCY 0 and 2),
// each with its own Avalon slave model, scoreboard queue and monitor.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1459998803;
  localparam int          TMO    = 8;
  localparam int          STUCK  = 1000;

  typedef struct packed {
    logic        match;
    logic        tmo;
    logic [31:0] id;
    logic [31:0] ts;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int inst, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got %0h expected %0h (t=%0t)", inst, name, act, exp, $time);
  endtask

  task automatic fail_note(input int inst, input string name);
    n_checks++;
    $display("FAIL u%0d %s: wait bound expired (t=%0t)", inst, name, $time);
  endtask

  function automatic logic [31:0] rand_word(input logic [31:0] good);
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return $urandom();
    if (r == 1) return good ^ (32'd1 << $urandom_range(0, 31));
    return good;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int LAT = (gi == 0) ? 0 : 2;

    logic        rst_n, start, av_address, av_read, av_waitrequest;
    logic [31:0] av_readdata, id_value, ts_value;
    logic        busy, done, match, timeout_err;
    logic [2:0]  fsm_state;
    exp_t        exp_q[$];
    int          cfg_s_id, cfg_s_ts;
    logic [31:0] cfg_id, cfg_ts;
    logic [31:0] m_id, m_ts;
    logic        blk_fin;

    niosii_system_sysid_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .READ_LATENCY       (LAT),
      .TIMEOUT_CYCLES     (TMO),
      .AUTO_START         (1'b1)
    ) dut (
      .clock          (clk),
      .reset_n        (rst_n),
      .start          (start),
      .av_address     (av_address),
      .av_read        (av_read),
      .av_waitrequest (av_waitrequest),
      .av_readdata    (av_readdata),
      .id_value       (id_value),
      .ts_value       (ts_value),
      .busy           (busy),
      .done           (done),
      .match          (match),
      .timeout_err    (timeout_err),
      .fsm_state      (fsm_state)
    );

    // Reference model: a read needs stall+1+LAT cycles (plus the idle gap for the
    // timestamp); more than TMO cycles aborts it. Start cycle is st, done follows FINISH.
    function automatic exp_t model(input int s1, input int s2, input logic [31:0] idw,
                                   input logic [31:0] tsw, input int st);
      exp_t e;
      int n1, n2;
      e.tmo = 1'b0;
      n1 = s1 + 1 + LAT;
      if (n1 > TMO) begin
        e.tmo = 1'b1;
        e.cyc = 32'(st + TMO + 2);
      end else begin
        m_id = idw;
        n2 = s2 + 2 + LAT;
        if (n2 > TMO) begin
          e.tmo = 1'b1;
          e.cyc = 32'(st + n1 + TMO + 2);
        end else begin
          m_ts = tsw;
          e.cyc = 32'(st + n1 + n2 + 2);
        end
      end
      e.id = m_id;
      e.ts = m_ts;
      e.match = !e.tmo && (m_id == EXP_ID) && (m_ts == EXP_TS);
      return e;
    endfunction

    // Avalon slave: stalls each read by its configured count, returns the word
    // LAT cycles after acceptance, and random garbage at all other times.
    initial begin
      int  stall_left, acc_cyc;
      logic in_read, pend, acc_addr;
      av_waitrequest = 1'b0;
      av_readdata = '0;
      in_read = 1'b0;
      pend = 1'b0;
      stall_left = 0;
      acc_cyc = 0;
      acc_addr = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          in_read = 1'b0;
          pend = 1'b0;
          av_waitrequest = 1'b0;
          av_readdata = $urandom();
        end else begin
          if (av_read) begin
            if (!in_read) begin
              in_read = 1'b1;
              stall_left = av_address ? cfg_s_ts : cfg_s_id;
            end else if (stall_left > 0) begin
              stall_left--;
            end
          end else begin
            in_read = 1'b0;
          end
          av_waitrequest = av_read && (stall_left > 0);
          if (av_read && !av_waitrequest) begin
            pend = 1'b1;
            acc_cyc = cyc;
            acc_addr = av_address;
          end
          if (pend && cyc == acc_cyc + LAT) begin
            av_readdata = acc_addr ? cfg_ts : cfg_id;
            pend = 1'b0;
          end else begin
            av_readdata = $urandom();
          end
        end
      end
    end

    // Monitor: Avalon hold rule during stalls, and scoreboard pop on every done.
    initial begin
      logic prev_stall, prev_addr;
      exp_t e;
      prev_stall = 1'b0;
      prev_addr = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
          prev_stall = 1'b0;
          continue;
        end
        if (prev_stall && !timeout_err) begin
          check(gi, "hold_read", 32'(av_read), 32'd1);
          check(gi, "hold_addr", 32'(av_address), 32'(prev_addr));
        end
        prev_stall = av_read && av_waitrequest;
        prev_addr = av_address;
        if (done) begin
          if (exp_q.size() == 0) begin
            fail_note(gi, "unexpected_done");
          end else begin
            e = exp_q.pop_front();
            check(gi, "done_cycle", 32'(cyc), e.cyc);
            check(gi, "match", 32'(match), 32'(e.match));
            check(gi, "timeout_err", 32'(timeout_err), 32'(e.tmo));
            check(gi, "id_value", id_value, e.id);
            check(gi, "ts_value", ts_value, e.ts);
            check(gi, "busy_at_done", 32'(busy), 32'd0);
          end
        end
      end
    end

    task automatic check_reset_values();
      check(gi, "rst_av_read", 32'(av_read), 32'd0);
      check(gi, "rst_av_address", 32'(av_address), 32'd0);
      check(gi, "rst_id_value", id_value, 32'd0);
      check(gi, "rst_ts_value", ts_value, 32'd0);
      check(gi, "rst_busy", 32'(busy), 32'd0);
      check(gi, "rst_done", 32'(done), 32'd0);
      check(gi, "rst_match", 32'(match), 32'd0);
      check(gi, "rst_timeout_err", 32'(timeout_err), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic wait_done(input bit noisy);
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (done) begin
          start = 1'b0;
          return;
        end
        start = (noisy && busy && $urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      fail_note(gi, "wait_done");
    endtask

    task automatic run_check(input int s1, input int s2, input logic [31:0] idw,
                             input logic [31:0] tsw, input bit noisy);
      cfg_s_id = s1;
      cfg_s_ts = s2;
      cfg_id = idw;
      cfg_ts = tsw;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      exp_q.push_back(model(s1, s2, idw, tsw, cyc));
      @(negedge clk);
      start = 1'b0;
      wait_done(noisy);
    endtask

    task automatic release_reset();
      cfg_s_id = 0;
      cfg_s_ts = 0;
      cfg_id = EXP_ID;
      cfg_ts = EXP_TS;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(0, 0, EXP_ID, EXP_TS, cyc));
      wait_done(1'b0);
    endtask

    // Driver: directed cases first, then randomized checks, then a reset mid-read.
    initial begin
      int s1, s2;
      bit found;
      blk_fin = 1'b0;
      rst_n = 1'b1;
      start = 1'b0;
      m_id = '0;
      m_ts = '0;
      cfg_s_id = 0;
      cfg_s_ts = 0;
      cfg_id = EXP_ID;
      cfg_ts = EXP_TS;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_reset_values();
      release_reset();

      run_check(3, 3, EXP_ID, EXP_TS, 1'b0);
      run_check(0, 0, 32'h0000_0001, EXP_TS, 1'b1);
      run_check(STUCK, 0, EXP_ID, EXP_TS, 1'b0);
      run_check(0, STUCK, EXP_ID, EXP_TS, 1'b1);
      run_check(0, 0, EXP_ID, EXP_TS, 1'b0);

      repeat (14) begin
        s1 = $urandom_range(0, 9);
        s2 = $urandom_range(0, 9);
        if (s1 == 9) s1 = STUCK;
        if (s2 == 9) s2 = STUCK;
        run_check(s1, s2, rand_word(EXP_ID), rand_word(EXP_TS), 1'($urandom_range(0, 1)));
      end

      // Reset while the timestamp read is in flight.
      cfg_s_id = 0;
      cfg_s_ts = 3;
      cfg_id = EXP_ID;
      cfg_ts = EXP_TS;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
        @(negedge clk);
        if (av_read && av_address) found = 1'b1;
      end
      if (!found) fail_note(gi, "wait_ts_read");
      rst_n = 1'b0;
      exp_q.delete();
      m_id = '0;
      m_ts = '0;
      #1 check_reset_values();
      @(negedge clk);
      release_reset();
      run_check(2, 1, EXP_ID, EXP_TS, 1'b1);

      repeat (10) @(negedge clk);
      check(gi, "exp_q_drained", 32'(exp_q.size()), 32'd0);
      blk_fin = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 40000 && !(g[0].blk_fin && g[1].blk_fin); k++) @(posedge clk);
    if (!(g[0].blk_fin && g[1].blk_fin)) fail_note(-1, "global_timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
